// File: rtl/inst_buffer_pkg.sv
// Shared frontend package for the instruction buffer.
// Holds the default buffer depth and the {pc, inst} entry type used by both
// the pointer/count logic (inst_buffer) and the storage array (ib_storage).
package inst_buffer_pkg;

    // Default number of buffer entries (power of two, at least 4).
    localparam int unsigned IbDepth = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ib_entry_t;

endpackage

// File: rtl/ib_storage.sv
// Instruction buffer storage: a 2-write / 2-read register array of ib_entry_t.
// No reset; entry contents are meaningless until written.
// Ports:
//   clk             clock, writes on rising edge
//   we0/waddr0/wdata0  write port 0
//   we1/waddr1/wdata1  write port 1 (never the same address as port 0 when both fire)
//   raddr0/rdata0   combinational read port 0
//   raddr1/rdata1   combinational read port 1
module ib_storage
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IbDepth,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  ib_entry_t     wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  ib_entry_t     wdata1,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output ib_entry_t     rdata0,
    output ib_entry_t     rdata1
);

    ib_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch (IF3) and decode: circular FIFO of
// {pc, inst} entries accepting up to two instructions and delivering up to
// two per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard all contents (priority over traffic)
//   pause                    backend stall, blocks dequeue
//   pause_req                stall request to fetch; from registered count only
//   in_valid, in_inst*, in_pc*   fetch slots, bit0/slot0 is older
//   out_valid, out_inst*, out_pc*  head entries to decode, bit0/slot0 is older
//   out_ready                decode takes every slot flagged in out_valid
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IbDepth
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pause,
    output logic        pause_req,
    input  logic [1:0]  in_valid,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    output logic [1:0]  out_valid,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          wr_en;
    logic          we0, we1;
    ib_entry_t     wdata0, wdata1;
    ib_entry_t     rdata0, rdata1;
    logic [1:0]    n_wr, n_rd;

    // Fewer than two free slots: upstream must hold. Registered count only.
    assign pause_req = count_q > CW'(DEPTH - 2);
    assign out_valid = {count_q >= CW'(2), count_q >= CW'(1)};

    // Upstream holds its registers while pause_req=1, so in_valid is ignored then.
    assign wr_en = !pause_req && !flush;
    assign we0   = wr_en && (|in_valid);
    assign we1   = wr_en && (&in_valid);

    // Compaction: a lone slot1 instruction goes through write port 0 at tail.
    always_comb begin
        wdata0 = in_valid[0] ? '{pc: in_pc0, inst: in_inst0} : '{pc: in_pc1, inst: in_inst1};
        wdata1 = '{pc: in_pc1, inst: in_inst1};
    end

    assign n_wr = {1'b0, we0} + {1'b0, we1};
    assign n_rd = (out_ready && !pause) ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;

    always_comb begin
        head_d  = head_q + AW'(n_rd);
        tail_d  = tail_q + AW'(n_wr);
        count_d = count_q + CW'(n_wr) - CW'(n_rd);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    ib_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail_q),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail_q + AW'(1)),
        .wdata1 (wdata1),
        .raddr0 (head_q),
        .raddr1 (head_q + AW'(1)),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    assign out_inst0 = rdata0.inst;
    assign out_pc0   = rdata0.pc;
    assign out_inst1 = rdata1.inst;
    assign out_pc1   = rdata1.pc;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_inst_buffer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, flush, pause, out_ready;
    logic        pause_req;
    logic [1:0]  in_valid, out_valid;
    logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
    logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;

    inst_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .pause     (pause),
        .pause_req (pause_req),
        .in_valid  (in_valid),
        .in_inst0  (in_inst0),
        .in_inst1  (in_inst1),
        .in_pc0    (in_pc0),
        .in_pc1    (in_pc1),
        .out_valid (out_valid),
        .out_inst0 (out_inst0),
        .out_inst1 (out_inst1),
        .out_pc0   (out_pc0),
        .out_pc1   (out_pc1),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: exp_q holds the entries the buffer contains, oldest first.
    // in_flight holds entries issued this cycle that land at the next edge.
    logic [63:0] exp_q[$];
    logic [63:0] in_flight[$];
    int          checks = 0;
    int          passes = 0;
    bit          checking_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare DUT outputs with the model mid-cycle, then advance the
    // model to what the next rising edge should produce.
    always @(negedge clk) begin
        int sz;
        int n;
        sz = exp_q.size();
        if (checking_on) begin
            chk("out_valid", 64'(out_valid), 64'({sz >= 2, sz >= 1}));
            chk("pause_req", 64'(pause_req), 64'(DEPTH - sz < 2));
            if (sz >= 1) chk("slot0", {out_pc0, out_inst0}, exp_q[0]);
            if (sz >= 2) chk("slot1", {out_pc1, out_inst1}, exp_q[1]);
        end
        if (rst || flush) begin
            exp_q.delete();
            in_flight.delete();
        end else begin
            n = (out_ready && !pause) ? ((sz >= 2) ? 2 : sz) : 0;
            for (int i = 0; i < n; i++) void'(exp_q.pop_front());
            while (in_flight.size() > 0) exp_q.push_back(in_flight.pop_front());
        end
    end

    // Drive one cycle of inputs; push accepted instructions into in_flight.
    task automatic drive_full(input logic r, input logic f, input logic p, input logic rdy,
                              input logic [1:0] v, input logic [31:0] pc0,
                              input logic [31:0] pc1);
        bit accept;
        rst       = r;
        flush     = f;
        pause     = p;
        out_ready = rdy;
        in_valid  = v;
        in_pc0    = pc0;
        in_pc1    = pc1;
        in_inst0  = $urandom;
        in_inst1  = $urandom;
        accept = !r && !f && (DEPTH - exp_q.size() >= 2);
        if (accept && v[0]) in_flight.push_back({in_pc0, in_inst0});
        if (accept && v[1]) in_flight.push_back({in_pc1, in_inst1});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic p, input logic rdy,
                         input logic [1:0] v);
        drive_full(r, f, p, rdy, v, $urandom, $urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pause = 1'b0; out_ready = 1'b0; in_valid = 2'b00;
        in_inst0 = '0; in_inst1 = '0; in_pc0 = '0; in_pc1 = '0;
        @(posedge clk);
        #1;
        checking_on = 1'b1;
        drive(1, 0, 0, 0, 2'b00);
        drive(0, 0, 0, 0, 2'b00);

        // Fill with pairs, no dequeue: 2,4,6,8 then held at full.
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 2'b11);
        // Drain two per cycle while feeding pairs; wraps the pointers.
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 2'b11);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2'b00);

        // Lone slot1 instruction is compacted into the head.
        drive_full(0, 0, 0, 0, 2'b10, 32'h1234_5678, 32'h8000_0004);
        drive(0, 0, 0, 0, 2'b00);
        chk("pc0_after_slot1_only", 64'(out_pc0), 64'h8000_0004);

        // Flush at count 5 with simultaneous enqueue and dequeue.
        drive(0, 1, 0, 0, 2'b00);
        drive(0, 0, 0, 0, 2'b11);
        drive(0, 0, 0, 0, 2'b11);
        drive(0, 0, 0, 0, 2'b01);
        drive(0, 1, 0, 1, 2'b11);
        drive(0, 0, 0, 0, 2'b00);

        // Backend pause at count 3 blocks dequeue.
        drive(0, 0, 0, 0, 2'b11);
        drive(0, 0, 0, 0, 2'b01);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 2'b00);

        // Reset mid-stream at count 6, then a fresh entry.
        drive(0, 1, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 2'b11);
        drive(1, 0, 0, 1, 2'b11);
        drive(0, 0, 0, 0, 2'b01);
        drive(0, 0, 0, 0, 2'b00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
        end

        drive(0, 0, 0, 0, 2'b00);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
